bidir_bus_arbiter: RTL and testbench

Sequences and shares one half-duplex bidirectional buffer link between two requesters, side A and side B. It drives the buffer's direction select (`dir`, 1 = A drives B) and a global driver enable. It enforces a dead turnaround window whenever the link reverses, so both sides never drive at once. Round-robin fairness and an optional burst limit stop either side from starving the other.

---
 rtl/bidir_arb_pkg.sv | 23 ++
 rtl/bidir_arb_timer.sv | 28 ++
 rtl/bidir_bus_arbiter.sv | 138 +++++++++++++
 tb/tb_bidir_bus_arbiter.sv | 198 +++++++++++++++++++
 4 files changed

// File: rtl/bidir_arb_pkg.sv
// Shared types and constants for the bidirectional bus arbiter.
package bidir_arb_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    TURN  = 2'd1,
    GNT_A = 2'd2,
    GNT_B = 2'd3
  } state_t;

  localparam logic DIR_A2B = 1'b1;
  localparam logic DIR_B2A = 1'b0;

  localparam logic OWNER_A = 1'b0;
  localparam logic OWNER_B = 1'b1;

  localparam int REV_CNT_W = 8;

  function automatic logic [REV_CNT_W-1:0] rev_inc(input logic [REV_CNT_W-1:0] v);
    return (&v) ? v : v + 1'b1;
  endfunction

endpackage

// File: rtl/bidir_arb_timer.sv
// Loadable down-counter with zero flag; shared by the turnaround countdown
// and the burst counter, which are never active at the same time.
module bidir_arb_timer #(
  parameter int W = 4
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         load,
  input  logic [W-1:0] load_val,
  input  logic         dec,
  output logic         zero
);

  logic [W-1:0] count_reg;

  always_ff @(posedge clk) begin
    if (rst) begin
      count_reg <= '0;
    end else if (load) begin
      count_reg <= load_val;
    end else if (dec && (count_reg != '0)) begin
      count_reg <= count_reg - 1'b1;
    end
  end

  assign zero = (count_reg == '0);

endmodule

// File: rtl/bidir_bus_arbiter.sv
// Half-duplex link arbiter with dead-cycle turnaround and round-robin ties.
// Define BIDIR_ARB_BURST_LIMIT_EN to enable MAX_BURST preemption.
module bidir_bus_arbiter
  import bidir_arb_pkg::*;
#(
  parameter int TURN_CYCLES = 2,
  parameter int MAX_BURST   = 16
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 req_a,
  input  logic                 req_b,
  output logic                 gnt_a,
  output logic                 gnt_b,
  output logic                 dir,
  output logic                 drv_en,
  output logic                 busy,
  output logic [REV_CNT_W-1:0] rev_cnt
);

  localparam int BURST_W = $clog2(MAX_BURST + 1);
  localparam int TIMER_W = (BURST_W > 4) ? BURST_W : 4;
  localparam logic [TIMER_W-1:0] TURN_LOAD = TIMER_W'(TURN_CYCLES - 1);
`ifdef BIDIR_ARB_BURST_LIMIT_EN
  localparam logic [TIMER_W-1:0] BURST_LOAD = TIMER_W'(MAX_BURST - 1);
`endif

  state_t               state_reg, state_next;
  logic                 dir_reg, dir_next;
  logic                 last_owner_reg, last_owner_next;
  logic [REV_CNT_W-1:0] rev_cnt_reg, rev_cnt_next;
  logic                 gnt_a_reg, gnt_b_reg, drv_en_reg, busy_reg;

  logic                 timer_load, timer_dec, timer_zero;
  logic [TIMER_W-1:0]   timer_val;
  logic                 target_a, own_req, other_req;

  bidir_arb_timer #(.W(TIMER_W)) u_timer (
    .clk      (clk),
    .rst      (rst),
    .load     (timer_load),
    .load_val (timer_val),
    .dec      (timer_dec),
    .zero     (timer_zero)
  );

  always_comb begin
    state_next      = state_reg;
    dir_next        = dir_reg;
    last_owner_next = last_owner_reg;
    rev_cnt_next    = rev_cnt_reg;
    timer_load      = 1'b0;
    timer_dec       = 1'b0;
    timer_val       = TURN_LOAD;
    target_a        = req_a && (!req_b || (last_owner_reg == OWNER_B));
    own_req         = (state_reg == GNT_A) ? req_a : req_b;
    other_req       = (state_reg == GNT_A) ? req_b : req_a;

    case (state_reg)
      IDLE: begin
        if (req_a || req_b) begin
          if ((target_a ? DIR_A2B : DIR_B2A) == dir_reg) begin
            state_next      = target_a ? GNT_A : GNT_B;
            last_owner_next = target_a ? OWNER_A : OWNER_B;
`ifdef BIDIR_ARB_BURST_LIMIT_EN
            timer_load      = 1'b1;
            timer_val       = BURST_LOAD;
`endif
          end else begin
            state_next   = TURN;
            dir_next     = ~dir_reg;
            rev_cnt_next = rev_inc(rev_cnt_reg);
            timer_load   = 1'b1;
          end
        end
      end
      TURN: begin
        // Requests are deliberately ignored here: the side chosen on entry wins.
        if (timer_zero) begin
          state_next      = (dir_reg == DIR_A2B) ? GNT_A : GNT_B;
          last_owner_next = (dir_reg == DIR_A2B) ? OWNER_A : OWNER_B;
`ifdef BIDIR_ARB_BURST_LIMIT_EN
          timer_load      = 1'b1;
          timer_val       = BURST_LOAD;
`endif
        end else begin
          timer_dec = 1'b1;
        end
      end
      GNT_A, GNT_B: begin
        if (!own_req) begin
          state_next = IDLE;
`ifdef BIDIR_ARB_BURST_LIMIT_EN
        end else if (timer_zero && other_req) begin
          state_next   = TURN;
          dir_next     = ~dir_reg;
          rev_cnt_next = rev_inc(rev_cnt_reg);
          timer_load   = 1'b1;
`endif
        end else begin
          timer_dec = 1'b1;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  // Outputs are registered from the next state so they line up with state_reg.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg      <= IDLE;
      dir_reg        <= DIR_A2B;
      last_owner_reg <= OWNER_B;
      rev_cnt_reg    <= '0;
      gnt_a_reg      <= 1'b0;
      gnt_b_reg      <= 1'b0;
      drv_en_reg     <= 1'b0;
      busy_reg       <= 1'b0;
    end else begin
      state_reg      <= state_next;
      dir_reg        <= dir_next;
      last_owner_reg <= last_owner_next;
      rev_cnt_reg    <= rev_cnt_next;
      gnt_a_reg      <= (state_next == GNT_A);
      gnt_b_reg      <= (state_next == GNT_B);
      drv_en_reg     <= (state_next == GNT_A) || (state_next == GNT_B);
      busy_reg       <= (state_next != IDLE);
    end
  end

  assign gnt_a   = gnt_a_reg;
  assign gnt_b   = gnt_b_reg;
  assign dir     = dir_reg;
  assign drv_en  = drv_en_reg;
  assign busy    = busy_reg;
  assign rev_cnt = rev_cnt_reg;

endmodule

// File: tb/tb_bidir_bus_arbiter.sv
// Directed self-checking bench for bidir_bus_arbiter (TURN_CYCLES=2, MAX_BURST=4).
module tb_bidir_bus_arbiter;

  localparam int TC = 2;
  localparam int MB = 4;

  // {gnt_a, gnt_b, dir, drv_en, busy}
  localparam logic [7:0] O_IDLE1 = 8'b000_00100;
  localparam logic [7:0] O_IDLE0 = 8'b000_00000;
  localparam logic [7:0] O_GA    = 8'b000_10111;
  localparam logic [7:0] O_GB    = 8'b000_01011;
  localparam logic [7:0] O_TURN0 = 8'b000_00001;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       req_a = 1'b0;
  logic       req_b = 1'b0;
  logic       gnt_a, gnt_b, dir, drv_en, busy;
  logic [7:0] rev_cnt;

  int n_cmp = 0;
  int n_bad = 0;

  bidir_bus_arbiter #(.TURN_CYCLES(TC), .MAX_BURST(MB)) dut (
    .clk     (clk),
    .rst     (rst),
    .req_a   (req_a),
    .req_b   (req_b),
    .gnt_a   (gnt_a),
    .gnt_b   (gnt_b),
    .dir     (dir),
    .drv_en  (drv_en),
    .busy    (busy),
    .rev_cnt (rev_cnt)
  );

  always #5 clk = ~clk;

  function automatic logic [7:0] outs();
    return {3'b000, gnt_a, gnt_b, dir, drv_en, busy};
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %b expected %b", tag, obs, exp);
    end
  endtask

  task automatic wait_gnt(input string tag, input bit side_a);
    bit got;
    got = 1'b0;
    for (int k = 0; k < 20 && !got; k++) begin
      tick();
      got = side_a ? gnt_a : gnt_b;
    end
    n_cmp++;
    assert (got) else begin
      n_bad++;
      $error("FAIL %s: observed no grant within 20 cycles, expected grant", tag);
    end
  endtask

  // Continuous safety checks: no double grant, dead window after each reversal.
  bit   rst_seen = 1'b1;
  logic dir_q = 1'b1;
  int   quiet = 0;

  always @(posedge clk) rst_seen = rst;

  always @(negedge clk) begin
    n_cmp++;
    assert (!(gnt_a && gnt_b)) else begin
      n_bad++;
      $error("FAIL dual_grant: observed gnt_a=%b gnt_b=%b expected not both", gnt_a, gnt_b);
    end
    if ((dir !== dir_q) && !rst_seen) quiet = TC;
    if (quiet > 0) begin
      n_cmp++;
      assert (drv_en === 1'b0) else begin
        n_bad++;
        $error("FAIL turn_window: observed drv_en=%b expected 0", drv_en);
      end
      quiet--;
    end
    dir_q = dir;
  end

  initial begin
    // Reset values
    rst = 1'b1; tick(); tick();
    chk("rst_outs", outs(), O_IDLE1);
    chk("rst_rev", rev_cnt, 8'd0);
    rst = 1'b0; tick();
    chk("idle_outs", outs(), O_IDLE1);

    // Same-direction grant, then reversal through IDLE and TURN
    req_a = 1'b1; tick();
    chk("t1_gnt_a", outs(), O_GA);
    chk("t1_rev", rev_cnt, 8'd0);
    req_a = 1'b0; req_b = 1'b1; tick();
    chk("t2_idle", outs(), O_IDLE1);
    tick();
    chk("t2_turn1", outs(), O_TURN0);
    chk("t2_rev", rev_cnt, 8'd1);
    tick();
    chk("t2_turn2", outs(), O_TURN0);
    tick();
    chk("t2_gnt_b", outs(), O_GB);
    req_b = 1'b0; tick();
    chk("t2_release", outs(), O_IDLE0);

    // Back-to-back same side: IDLE one cycle, no TURN
    req_b = 1'b1; tick();
    chk("b2b_g1", outs(), O_GB);
    req_b = 1'b0; tick();
    chk("b2b_idle", outs(), O_IDLE0);
    req_b = 1'b1; tick();
    chk("b2b_g2", outs(), O_GB);
    chk("b2b_rev", rev_cnt, 8'd1);
    req_b = 1'b0; tick();

    // Round-robin on ties
    rst = 1'b1; tick();
    rst = 1'b0; req_a = 1'b1; req_b = 1'b1; tick();
    chk("rr_first_a", outs(), O_GA);
    req_a = 1'b0; req_b = 1'b0; tick();
    chk("rr_idle", outs(), O_IDLE1);
    req_a = 1'b1; req_b = 1'b1; tick();
    chk("rr_turn", outs(), O_TURN0);
    tick(); tick();
    chk("rr_second_b", outs(), O_GB);
    chk("rr_rev", rev_cnt, 8'd1);
    req_a = 1'b0; req_b = 1'b0; tick();

    // Burst limit
    rst = 1'b1; tick();
    rst = 1'b0; req_a = 1'b1; tick();
    chk("bu_g0", outs(), O_GA);
    req_b = 1'b1;
    for (int k = 1; k < MB; k++) begin
      tick();
      chk("bu_hold", outs(), O_GA);
    end
    tick();
`ifdef BIDIR_ARB_BURST_LIMIT_EN
    chk("bu_pre_turn", outs(), O_TURN0);
    chk("bu_rev", rev_cnt, 8'd1);
    tick();
    chk("bu_turn2", outs(), O_TURN0);
    tick();
    chk("bu_gnt_b", outs(), O_GB);
`else
    for (int k = 0; k < 20; k++) begin
      chk("bu_hold_long", outs(), O_GA);
      tick();
    end
    chk("bu_rev_none", rev_cnt, 8'd0);
`endif
    req_a = 1'b0; req_b = 1'b0; tick();

    // Reset during TURN and during GNT_B
    rst = 1'b1; tick();
    rst = 1'b0; req_b = 1'b1; tick();
    chk("rt_turn", outs(), O_TURN0);
    rst = 1'b1; tick();
    chk("rt_rst_turn", outs(), O_IDLE1);
    chk("rt_rst_turn_rev", rev_cnt, 8'd0);
    rst = 1'b0; tick(); tick(); tick();
    chk("rt_gnt_b", outs(), O_GB);
    rst = 1'b1; tick();
    chk("rt_rst_gnt", outs(), O_IDLE1);
    chk("rt_rst_gnt_rev", rev_cnt, 8'd0);
    rst = 1'b0; req_b = 1'b0; tick();

    // 300 forced reversals: rev_cnt saturates at 255
    for (int i = 0; i < 150; i++) begin
      req_a = 1'b0; req_b = 1'b1;
      wait_gnt("sat_b", 1'b0);
      req_b = 1'b0; req_a = 1'b1;
      wait_gnt("sat_a", 1'b1);
      if (i == 49) chk("sat_mid_rev", rev_cnt, 8'd100);
    end
    chk("sat_rev", rev_cnt, 8'd255);
    req_a = 1'b0; tick();
    chk("sat_idle", outs(), O_IDLE1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
